// File: rtl/comparator_serial.sv
// rtl/comparator_serial.sv - MSB-first sliced magnitude comparator with early exit (optional signed mode via COMPARATOR_SIGNED_EN)
module comparator_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             gt_out,
    output logic             eq_out,
    output logic             lt_out
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(NSLICE - 1);
    localparam logic [CHUNK-1:0] SLICE_MSB = CHUNK'(1) << (CHUNK - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDXW-1:0]  r_idx;
    logic [31:0]      w_shamt;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [CHUNK-1:0] w_sa;
    logic [CHUNK-1:0] w_sb;

`ifdef COMPARATOR_SIGNED_EN
    logic             r_sgn;
    logic             w_flip;
`else
    logic             w_unused_sgn;
    assign w_unused_sgn = signed_mode;
`endif

    // Bring the slice under examination down to the bottom CHUNK bits
    assign w_shamt   = 32'(r_idx) * 32'(CHUNK);
    assign w_a_shift = r_a >> w_shamt;
    assign w_b_shift = r_b >> w_shamt;

`ifdef COMPARATOR_SIGNED_EN
    // Offset-binary trick: flipping the sign bit on both operands turns a
    // two's-complement compare into an unsigned one on the top slice only
    assign w_flip = r_sgn && (r_idx == LAST_IDX);
    assign w_sa   = w_a_shift[CHUNK-1:0] ^ (w_flip ? SLICE_MSB : '0);
    assign w_sb   = w_b_shift[CHUNK-1:0] ^ (w_flip ? SLICE_MSB : '0);
`else
    assign w_sa   = w_a_shift[CHUNK-1:0];
    assign w_sb   = w_b_shift[CHUNK-1:0];
`endif

    // Control FSM: capture on start, scan slices MSB-first, register result on exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            gt_out  <= 1'b0;
            eq_out  <= 1'b0;
            lt_out  <= 1'b0;
`ifdef COMPARATOR_SIGNED_EN
            r_sgn   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_idx   <= LAST_IDX;
                        busy    <= 1'b1;
                        r_state <= RUN;
`ifdef COMPARATOR_SIGNED_EN
                        r_sgn   <= signed_mode;
`endif
                    end
                end
                RUN: begin
                    if (w_sa != w_sb) begin
                        gt_out  <= (w_sa > w_sb);
                        lt_out  <= (w_sa < w_sb);
                        eq_out  <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_idx == '0) begin
                        gt_out  <= 1'b0;
                        lt_out  <= 1'b0;
                        eq_out  <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/comparator_serial.md
# comparator_serial

Parametrised, multi-cycle magnitude comparator and successor to the fixed 16-bit combinational comparator. It is used where wide operands would make a flat compare the critical path. Operands are captured on a start strobe and compared MSB-first in CHUNK-bit slices, one slice per clock, terminating early at the first unequal slice. The result is registered, pulsed with `done` and held until the next completed compare. Optional signed mode is compiled in via macro.

## Interface
Parameters:
- WIDTH, 16, operand width in bits; must be ≥ 1
- CHUNK, 4, slice width examined per cycle; WIDTH % CHUNK must be 0; CHUNK == WIDTH gives single-cycle compare
- NSLICE (local), WIDTH/CHUNK

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a compare; accepted only when busy == 0
- a  in  WIDTH  operand A, sampled on accepted start only
- b  in  WIDTH  operand B, sampled on accepted start only
- signed_mode  in  1  1 = two's-complement compare; sampled with a/b; ignored without COMPARATOR_SIGNED_EN
- busy  out  1  compare in progress
- done  out  1  one-cycle pulse, result valid and updated this cycle
- gt_out  out  1  A > B (registered, held)
- eq_out  out  1  A == B (registered, held)
- lt_out  out  1  A < B (registered, held)

## Operation
- FSM states: IDLE, RUN.
- IDLE: on start == 1, capture a, b and signed_mode into internal regs, set slice index idx = NSLICE-1, go to RUN, busy = 1.
- RUN, each cycle: compare captured slice idx of A against slice idx of B.
  - Slices unequal: set gt/lt from slice compare, eq = 0, done = 1, go to IDLE.
  - Slices equal, idx == 0: eq = 1, gt = lt = 0, done = 1, go to IDLE.
  - Slices equal, idx > 0: idx decrements, stay in RUN.
- Signed mode, only when compiled in and captured signed_mode == 1: the MSB of the top slice (idx == NSLICE-1) is inverted on both operands before the compare, which is offset-binary equivalence. All other slices compare unsigned.
- gt_out/eq_out/lt_out are one-hot after the first done. They change only on a done edge and hold the previous result while busy.
- start while busy is ignored; the captured operands are unaffected.
- Changing a/b/signed_mode after acceptance has no effect on the result in progress.
- Reset (any time, including mid-RUN): state = IDLE; busy, done, gt_out, eq_out, lt_out all 0; idx and operand regs cleared. Outputs stay all-zero ("no result") until the first done.

## Timing
- Edge E0 accepts start; busy = 1 after E0.
- Result edge: E(k), k = 1 + number of leading equal slices, 1 ≤ k ≤ NSLICE. At that edge done = 1, the outputs update and busy = 0.
- done is high for exactly one cycle, and no two done pulses are ever adjacent.
- Back-to-back: start asserted during the done cycle is accepted, since busy = 0. Steady-state throughput is one compare per k+1 cycles.
- Default config: worst-case latency 4 cycles (equal operands); best case 1 cycle (top nibble differs).
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.

## Configuration
- COMPARATOR_SIGNED_EN defined: the signed_mode register and top-slice MSB inversion are present; signed_mode == 1 gives a two's-complement compare.
- Not defined: the signed_mode port exists but is unused, no signed logic is synthesised, and every compare is unsigned.

## Test plan
- Reset then idle: rst_n low, then high with no start → busy, done, gt_out, eq_out, lt_out all 0.
- Early exit: WIDTH=16, CHUNK=4, a=16'hA000, b=16'h1FFF, start → done at E1, gt_out=1, eq_out=0, lt_out=0.
- Full scan equal: a=b=16'h1234 → done at E4, eq_out=1. Then a=16'h1234, b=16'h1235 issued in the done cycle → accepted, done 4 cycles later, lt_out=1.
- Signed (macro on): a=16'hFFFF, b=16'h0001, signed_mode=1 → lt_out=1 at E1. Same operands with signed_mode=0 → gt_out=1. With the macro off, both give gt_out=1.
- Ignored start/operand change: a=16'h0F00, b=16'h0F01 accepted, then start pulsed and a/b changed to 0 during RUN → single done at E4 with lt_out=1.
- Reset mid-op: assert rst_n low at E2 of an equal-operand compare → busy, done and all flags 0 immediately, and no done follows release.
